// File: rtl/bitty_pkg.sv
// Shared types and constants for the bitty control unit: states, instruction
// formats, field positions and decoded-instruction payload.
package bitty_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned REG_AW  = 3;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned FIELD_RW = 3;

  localparam int unsigned RX_LSB  = 13;
  localparam int unsigned RY_LSB  = 10;
  localparam int unsigned IMM_LSB = 5;
  localparam int unsigned OP_LSB  = 2;
  localparam int unsigned FMT_LSB = 0;

  localparam logic [1:0] FMT_RR = 2'b00;
  localparam logic [1:0] FMT_RI = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_S,
    COMPUTE,
    WRITEBACK,
    DONE
  } state_t;

  typedef struct packed {
    logic [FIELD_RW-1:0] rx;
    logic [FIELD_RW-1:0] ry;
    logic [IMM_W-1:0]    imm8;
    logic [ALU_W-1:0]    alu_op;
    logic [1:0]          fmt;
    logic                legal;
  } decode_t;

endpackage

// File: rtl/bitty_control_unit_if.sv
// Instruction handshake plus datapath control bundle; master is the control
// unit, slave is the instruction source / datapath side.
interface bitty_control_unit_if #(
  parameter int unsigned DATA_W = bitty_pkg::DATA_W,
  parameter int unsigned REG_AW = bitty_pkg::REG_AW
);
  logic                           instr_valid;
  logic                           instr_ready;
  logic [bitty_pkg::INSTR_W-1:0]  instruction;
  logic [REG_AW-1:0]              rf_rd_addr;
  logic                           en_s;
  logic                           en_c;
  logic                           mux_sel;
  logic [DATA_W-1:0]              imm_out;
  logic [bitty_pkg::ALU_W-1:0]    alu_sel;
  logic                           rf_we;
  logic [REG_AW-1:0]              rf_wr_addr;
  logic                           busy;
  logic                           done;
  logic                           illegal;

  modport master (
    input  instr_valid, instruction,
    output instr_ready, rf_rd_addr, en_s, en_c, mux_sel, imm_out, alu_sel,
           rf_we, rf_wr_addr, busy, done, illegal
  );

  modport slave (
    output instr_valid, instruction,
    input  instr_ready, rf_rd_addr, en_s, en_c, mux_sel, imm_out, alu_sel,
           rf_we, rf_wr_addr, busy, done, illegal
  );
endinterface

// File: rtl/bitty_instr_decode.sv
// Combinational field extraction from a 16-bit bitty instruction word.
module bitty_instr_decode
  import bitty_pkg::*;
(
  input  logic [INSTR_W-1:0] word,
  output decode_t            dec
);

  always_comb begin
    dec        = '0;
    dec.rx     = word[RX_LSB +: FIELD_RW];
    dec.ry     = word[RY_LSB +: FIELD_RW];
    dec.imm8   = word[IMM_LSB +: IMM_W];
    dec.fmt    = word[FMT_LSB +: 2];
    dec.legal  = (dec.fmt == FMT_RR) || (dec.fmt == FMT_RI);
    // Reg-imm reuses bit 5 as the imm8 LSB, so its opcode is only 3 bits wide.
    if (dec.fmt == FMT_RI)
      dec.alu_op = {1'b0, word[OP_LSB +: ALU_W-1]};
    else
      dec.alu_op = word[OP_LSB +: ALU_W];
  end

endmodule

// File: rtl/bitty_control_unit.sv
// Multi-cycle sequencer: latches one instruction per handshake and steps the
// datapath through S-load, ALU compute and writeback with registered controls.
module bitty_control_unit
  import bitty_pkg::*;
#(
  parameter int unsigned DATA_W = bitty_pkg::DATA_W,
  parameter int unsigned REG_AW = bitty_pkg::REG_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bitty_control_unit_if.master bus
);

  state_t             state;
  logic [INSTR_W-1:0] ir;
  logic [INSTR_W-1:0] dec_word;
  decode_t            dec;

  // In IDLE the incoming word is decoded so FETCH_S controls are ready at entry.
  assign dec_word = (state == IDLE) ? bus.instruction : ir;

  bitty_instr_decode u_decode (
    .word (dec_word),
    .dec  (dec)
  );

  // Sequencer with registered controls; pulse-type outputs default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ir              <= '0;
      bus.instr_ready <= 1'b1;
      bus.busy        <= 1'b0;
      bus.en_s        <= 1'b0;
      bus.en_c        <= 1'b0;
      bus.rf_we       <= 1'b0;
      bus.done        <= 1'b0;
      bus.illegal     <= 1'b0;
      bus.mux_sel     <= 1'b0;
      bus.alu_sel     <= '0;
      bus.rf_rd_addr  <= '0;
      bus.rf_wr_addr  <= '0;
      bus.imm_out     <= '0;
    end else begin
      bus.en_s       <= 1'b0;
      bus.en_c       <= 1'b0;
      bus.rf_we      <= 1'b0;
      bus.done       <= 1'b0;
      bus.illegal    <= 1'b0;
      bus.mux_sel    <= 1'b0;
      bus.alu_sel    <= '0;
      bus.rf_rd_addr <= '0;
      bus.rf_wr_addr <= '0;

      case (state)
        IDLE: begin
          if (bus.instr_valid && bus.instr_ready) begin
            ir              <= bus.instruction;
            bus.instr_ready <= 1'b0;
            bus.busy        <= 1'b1;
            if (dec.legal) begin
              state          <= FETCH_S;
              bus.en_s       <= 1'b1;
              bus.rf_rd_addr <= REG_AW'(dec.rx);
              bus.imm_out    <= (dec.fmt == FMT_RI) ? DATA_W'(dec.imm8) : '0;
            end else begin
              state       <= DONE;
              bus.done    <= 1'b1;
              bus.illegal <= 1'b1;
            end
          end
        end
        FETCH_S: begin
          state          <= COMPUTE;
          bus.en_c       <= 1'b1;
          bus.rf_rd_addr <= REG_AW'(dec.ry);
          bus.mux_sel    <= dec.fmt[0];
          bus.alu_sel    <= dec.alu_op;
        end
        COMPUTE: begin
          state          <= WRITEBACK;
          bus.rf_we      <= 1'b1;
          bus.rf_wr_addr <= REG_AW'(dec.rx);
        end
        WRITEBACK: begin
          state       <= DONE;
          bus.done    <= 1'b1;
          bus.imm_out <= '0;
        end
        DONE: begin
          state           <= IDLE;
          bus.instr_ready <= 1'b1;
          bus.busy        <= 1'b0;
        end
        default: begin
          state           <= IDLE;
          bus.instr_ready <= 1'b1;
          bus.busy        <= 1'b0;
          bus.imm_out     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitty_control_unit.sv
// Directed, table-driven bench for bitty_control_unit plus reset-abort sequence.
module tb_bitty_control_unit;

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        en_s;
    logic        en_c;
    logic        mux_sel;
    logic        rf_we;
    logic        done;
    logic        illegal;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [3:0]  alu;
    logic [15:0] imm;
  } outs_t;

  typedef struct {
    logic        valid;
    logic [15:0] instr;
    outs_t       exp;
  } vec_t;

  localparam logic [15:0] W_RR  = 16'h4C08; // rx=2 ry=3 op=2
  localparam logic [15:0] W_RI  = 16'hB4F5; // rx=5 imm8=A7 op=101
  localparam logic [15:0] W_IL2 = 16'h0002;
  localparam logic [15:0] W_IL3 = 16'hFFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  bitty_control_unit_if bus ();

  bitty_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic outs_t o_idle();
    outs_t o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_fetch(logic [2:0] rd, logic [15:0] imm);
    outs_t o = '0;
    o.busy = 1'b1; o.en_s = 1'b1; o.rd = rd; o.imm = imm;
    return o;
  endfunction

  function automatic outs_t o_comp(logic [2:0] rd, logic mux, logic [3:0] alu, logic [15:0] imm);
    outs_t o = '0;
    o.busy = 1'b1; o.en_c = 1'b1; o.rd = rd; o.mux_sel = mux; o.alu = alu; o.imm = imm;
    return o;
  endfunction

  function automatic outs_t o_wb(logic [2:0] wr, logic [15:0] imm);
    outs_t o = '0;
    o.busy = 1'b1; o.rf_we = 1'b1; o.wr = wr; o.imm = imm;
    return o;
  endfunction

  function automatic outs_t o_done(logic ill);
    outs_t o = '0;
    o.busy = 1'b1; o.done = 1'b1; o.illegal = ill;
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.ready   = bus.instr_ready;
    o.busy    = bus.busy;
    o.en_s    = bus.en_s;
    o.en_c    = bus.en_c;
    o.mux_sel = bus.mux_sel;
    o.rf_we   = bus.rf_we;
    o.done    = bus.done;
    o.illegal = bus.illegal;
    o.rd      = bus.rf_rd_addr;
    o.wr      = bus.rf_wr_addr;
    o.alu     = bus.alu_sel;
    o.imm     = bus.imm_out;
    return o;
  endfunction

  task automatic check(input string name, input outs_t exp);
    outs_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rdy=%b bsy=%b s=%b c=%b mux=%b we=%b dn=%b il=%b rd=%0d wr=%0d alu=%h imm=%h, expected rdy=%b bsy=%b s=%b c=%b mux=%b we=%b dn=%b il=%b rd=%0d wr=%0d alu=%h imm=%h",
               name, act.ready, act.busy, act.en_s, act.en_c, act.mux_sel, act.rf_we, act.done,
               act.illegal, act.rd, act.wr, act.alu, act.imm,
               exp.ready, exp.busy, exp.en_s, exp.en_c, exp.mux_sel, exp.rf_we, exp.done,
               exp.illegal, exp.rd, exp.wr, exp.alu, exp.imm);
    end
  endtask

  // Drive inputs on the falling edge, check registered outputs just after the rising edge.
  task automatic step(input logic v, input logic [15:0] w, input string name, input outs_t exp);
    @(negedge clk);
    bus.instr_valid = v;
    bus.instruction = w;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  vec_t vecs[24];

  initial begin
    bus.instr_valid = 1'b0;
    bus.instruction = 16'h0000;

    vecs[0]  = '{1'b1, W_RR,  o_fetch(3'd2, 16'h0000)};
    vecs[1]  = '{1'b0, 16'h0, o_comp(3'd3, 1'b0, 4'h2, 16'h0000)};
    vecs[2]  = '{1'b1, W_IL3, o_wb(3'd2, 16'h0000)};
    vecs[3]  = '{1'b0, 16'h0, o_done(1'b0)};
    vecs[4]  = '{1'b0, 16'h0, o_idle()};
    vecs[5]  = '{1'b1, W_RI,  o_fetch(3'd5, 16'h00A7)};
    vecs[6]  = '{1'b0, 16'h0, o_comp(3'd5, 1'b1, 4'h5, 16'h00A7)};
    vecs[7]  = '{1'b0, 16'h0, o_wb(3'd5, 16'h00A7)};
    vecs[8]  = '{1'b0, 16'h0, o_done(1'b0)};
    vecs[9]  = '{1'b0, 16'h0, o_idle()};
    vecs[10] = '{1'b1, W_IL2, o_done(1'b1)};
    vecs[11] = '{1'b0, 16'h0, o_idle()};
    vecs[12] = '{1'b1, W_IL3, o_done(1'b1)};
    vecs[13] = '{1'b1, W_RR,  o_idle()};
    vecs[14] = '{1'b1, W_RR,  o_fetch(3'd2, 16'h0000)};
    vecs[15] = '{1'b1, W_RI,  o_comp(3'd3, 1'b0, 4'h2, 16'h0000)};
    vecs[16] = '{1'b1, W_RI,  o_wb(3'd2, 16'h0000)};
    vecs[17] = '{1'b1, W_RI,  o_done(1'b0)};
    vecs[18] = '{1'b1, W_RI,  o_idle()};
    vecs[19] = '{1'b1, W_RI,  o_fetch(3'd5, 16'h00A7)};
    vecs[20] = '{1'b0, 16'h0, o_comp(3'd5, 1'b1, 4'h5, 16'h00A7)};
    vecs[21] = '{1'b0, 16'h0, o_wb(3'd5, 16'h00A7)};
    vecs[22] = '{1'b0, 16'h0, o_done(1'b0)};
    vecs[23] = '{1'b0, 16'h0, o_idle()};

    #12;
    check("reset", o_idle());
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 16'h0, "idle_after_reset", o_idle());

    for (int i = 0; i < 24; i++)
      step(vecs[i].valid, vecs[i].instr, $sformatf("vec%0d", i), vecs[i].exp);

    // Asynchronous reset during COMPUTE aborts the instruction with no writeback or done.
    step(1'b1, W_RR, "abort_fetch", o_fetch(3'd2, 16'h0000));
    step(1'b0, 16'h0, "abort_compute", o_comp(3'd3, 1'b0, 4'h2, 16'h0000));
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_async", o_idle());
    step(1'b1, W_RR, "abort_held0", o_idle());
    step(1'b0, 16'h0, "abort_held1", o_idle());
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 16'h0, "abort_release", o_idle());
    step(1'b0, 16'h0, "abort_no_done", o_idle());

    step(1'b1, W_RI,  "post_fetch",   o_fetch(3'd5, 16'h00A7));
    step(1'b0, 16'h0, "post_compute", o_comp(3'd5, 1'b1, 4'h5, 16'h00A7));
    step(1'b0, 16'h0, "post_wb",      o_wb(3'd5, 16'h00A7));
    step(1'b0, 16'h0, "post_done",    o_done(1'b0));
    step(1'b0, 16'h0, "post_idle",    o_idle());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
